// File: rtl/key_event_decoder_pkg.sv
// Shared key-event definitions: FSM encoding, default tick constants, event bundle order.
package key_event_decoder_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESS1   = 3'd1,
        GAP      = 3'd2,
        PRESS2   = 3'd3,
        LONGHOLD = 3'd4
    } key_state_t;

    // Enable tick period in microseconds (~1.31 ms).
    localparam int TICK_US = 1311;

    // Rounded conversion of a duration in milliseconds to enable ticks.
    function automatic int ms_to_ticks(input int ms);
        return (ms * 1000 + TICK_US / 2) / TICK_US;
    endfunction

    localparam int DEF_LONG_TICKS   = ms_to_ticks(800);
    localparam int DEF_REPEAT_TICKS = ms_to_ticks(200);
    localparam int DEF_DCLICK_TICKS = ms_to_ticks(300);
    localparam int DEF_CNT_WIDTH    = 10;

    // Event bundle as consumed by the player control FSM, lsb first: click, dclick, long, repeat.
    typedef struct packed {
        logic rpt;
        logic long_press;
        logic dclick;
        logic click;
    } key_evt_t;

endpackage

// File: rtl/dffre.sv
// Generic register with synchronous reset to INIT and load enable.
// Latency: 1 clk from d to q.
// Backpressure: none; en simply holds the current value.
module dffre #(
    parameter int               WIDTH = 1,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             r,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (r) begin
            q <= INIT;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/key_tick_timer.sv
// En-gated saturating tick counter with clear and terminal compare against a selectable limit.
// Latency: at_limit is combinational from the count register and en.
// Backpressure: none; clear takes priority over counting.
module key_tick_timer
    import key_event_decoder_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 clear,
    input  logic [CNT_WIDTH-1:0] limit,
    output logic                 at_limit
);

    logic [CNT_WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

    // Only meaningful on a tick, so the compare is qualified by en here.
    assign at_limit = en && (count == limit);

endmodule

// File: rtl/key_event_decoder.sv
// Classifies one debounced key into click / double-click / long-press / repeat pulses.
// Latency: pulses are registered, high for one clk after the deciding edge.
// Backpressure: none; pulses are fire-and-forget, one per cycle at most.
module key_event_decoder
    import key_event_decoder_pkg::*;
#(
    parameter int LONG_TICKS   = DEF_LONG_TICKS,
    parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
    parameter int DCLICK_TICKS = DEF_DCLICK_TICKS,
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic in,
    output logic click,
    output logic dclick,
    output logic long_press,
    output logic rpt,
    output logic held
);

    logic                 in_q;
    logic                 rise;
    logic                 fall;
    logic [2:0]           state_raw;
    key_state_t           state;
    key_state_t           next_state;
    logic                 restart;
    logic                 clear;
    logic [CNT_WIDTH-1:0] limit;
    logic                 at_limit;
    key_evt_t             evt;
    key_evt_t             evt_q;
    logic                 held_q;

    // in_q comes out of reset high so a key held through reset needs a release first.
    dffre #(.WIDTH(1), .INIT(1'b1)) u_in_q (
        .clk (clk),
        .r   (reset),
        .en  (1'b1),
        .d   (in),
        .q   (in_q)
    );

    dffre #(.WIDTH(3), .INIT(3'(IDLE))) u_state (
        .clk (clk),
        .r   (reset),
        .en  (1'b1),
        .d   (3'(next_state)),
        .q   (state_raw)
    );

    assign state = key_state_t'(state_raw);
    assign rise  = in & ~in_q;
    assign fall  = ~in & in_q;

    always_comb begin
        limit = '1;
        case (state)
            PRESS1:   limit = CNT_WIDTH'(LONG_TICKS - 1);
            GAP:      limit = CNT_WIDTH'(DCLICK_TICKS - 1);
            LONGHOLD: limit = CNT_WIDTH'(REPEAT_TICKS - 1);
            default:  limit = '1;
        endcase
    end

    key_tick_timer #(.CNT_WIDTH(CNT_WIDTH)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .clear    (clear),
        .limit    (limit),
        .at_limit (at_limit)
    );

    // Edges are tested before timeouts so an edge on the boundary tick wins.
    always_comb begin
        next_state = state;
        evt        = '0;
        restart    = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    next_state = PRESS1;
                end
            end
            PRESS1: begin
                if (fall) begin
                    next_state = GAP;
                end else if (at_limit) begin
                    next_state     = LONGHOLD;
                    evt.long_press = 1'b1;
                end
            end
            GAP: begin
                if (rise) begin
                    next_state = PRESS2;
                end else if (at_limit) begin
                    next_state = IDLE;
                    evt.click  = 1'b1;
                end
            end
            PRESS2: begin
                if (fall) begin
                    next_state = IDLE;
                    evt.dclick = 1'b1;
                end
            end
            LONGHOLD: begin
                if (fall) begin
                    next_state = IDLE;
                end else if (at_limit) begin
                    evt.rpt = 1'b1;
                    restart = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign clear = (next_state != state) || restart;

    always_ff @(posedge clk) begin
        if (reset) begin
            evt_q  <= '0;
            held_q <= 1'b0;
        end else begin
            evt_q  <= evt;
            held_q <= (next_state == LONGHOLD);
        end
    end

    assign click      = evt_q.click;
    assign dclick     = evt_q.dclick;
    assign long_press = evt_q.long_press;
    assign rpt        = evt_q.rpt;
    assign held       = held_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder: per-cycle vector table with en every clk, then tick-based sequences.
module tb_key_event_decoder;

    localparam logic [4:0] EC = 5'b00001; // click
    localparam logic [4:0] ED = 5'b00010; // dclick
    localparam logic [4:0] EL = 5'b00100; // long_press
    localparam logic [4:0] ER = 5'b01000; // repeat
    localparam logic [4:0] EH = 5'b10000; // held

    logic clk = 1'b0;
    logic reset;
    logic en;
    logic in;
    logic click, dclick, long_press, rpt, held;

    always #5 clk = ~clk;

    key_event_decoder #(
        .LONG_TICKS   (8),
        .REPEAT_TICKS (4),
        .DCLICK_TICKS (5),
        .CNT_WIDTH    (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .in         (in),
        .click      (click),
        .dclick     (dclick),
        .long_press (long_press),
        .rpt        (rpt),
        .held       (held)
    );

    typedef struct {
        logic       rst;
        logic       in;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ticks = 0;
    int en_div = 1;
    logic last_en = 1'b0;

    int n_click, n_dclick, n_long, n_rpt, multi;
    int t_click, t_long, c_dclick;
    int rpt_t[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clr_log();
        n_click = 0; n_dclick = 0; n_long = 0; n_rpt = 0;
        t_click = -1; t_long = -1; c_dclick = -1;
        rpt_t.delete();
    endtask

    // One clk: en is scheduled here, outputs are sampled 1 time unit after the edge.
    task automatic step();
        en = (en_div == 1) || ((cyc % en_div) == en_div - 1);
        last_en = en;
        @(posedge clk);
        #1;
        cyc++;
        if (last_en) ticks++;
        if (click)      begin n_click++;  t_click = ticks; end
        if (dclick)     begin n_dclick++; c_dclick = cyc;  end
        if (long_press) begin n_long++;   t_long = ticks;  end
        if (rpt)        begin n_rpt++;    rpt_t.push_back(ticks); end
        if ((int'(click) + int'(dclick) + int'(long_press) + int'(rpt)) > 1) multi++;
    endtask

    task automatic wait_ticks(input int n);
        int target;
        target = ticks + n;
        while (ticks < target) step();
    endtask

    task automatic sync_tick();
        do step(); while (!last_en);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic add_n(input int n, input logic r, input logic i, input logic [4:0] e);
        vec_t v;
        v.rst = r; v.in = i; v.exp = e;
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endtask

    initial begin
        int t0, tf, c0;
        int held_bad;
        logic [4:0] got;

        reset = 1'b1; en = 1'b1; in = 1'b0; multi = 0;
        clr_log();

        // en every clk: long press after 8 clks of PRESS1, repeat every 4, click/dclick, boundaries.
        add_n(1, 1, 0, 5'b0);       // reset cycle
        add_n(1, 0, 0, 5'b0);       // in_q drops, fall ignored in IDLE
        add_n(1, 0, 1, 5'b0);       // press accepted
        add_n(7, 0, 1, 5'b0);
        add_n(1, 0, 1, EL | EH);    // 9th clk with in high
        add_n(3, 0, 1, EH);
        add_n(1, 0, 1, ER | EH);
        add_n(2, 0, 0, 5'b0);       // release from hold: no click
        add_n(2, 0, 1, 5'b0);       // short press
        add_n(5, 0, 0, 5'b0);       // gap ticks 0..4
        add_n(1, 0, 0, EC);
        add_n(1, 0, 0, 5'b0);
        add_n(1, 0, 1, 5'b0);       // double click
        add_n(1, 0, 0, 5'b0);
        add_n(2, 0, 1, 5'b0);
        add_n(1, 0, 0, ED);
        add_n(1, 0, 0, 5'b0);
        add_n(1, 0, 1, 5'b0);       // second press lands on the gap timeout
        add_n(5, 0, 0, 5'b0);
        add_n(1, 0, 1, 5'b0);
        add_n(1, 0, 0, ED);
        add_n(1, 0, 0, 5'b0);
        add_n(1, 0, 1, 5'b0);       // reset in PRESS1
        add_n(1, 1, 0, 5'b0);
        add_n(1, 0, 0, 5'b0);

        en_div = 1;
        foreach (tbl[k]) begin
            reset = tbl[k].rst;
            in    = tbl[k].in;
            step();
            got = {held, rpt, long_press, dclick, click};
            chk($sformatf("vec%0d", k), int'(got), int'(tbl[k].exp));
        end

        en_div = 4;
        in = 1'b0;
        do_reset();
        step();

        // Click: 3-tick press, click 5 ticks after release.
        sync_tick(); clr_log();
        in = 1'b1; wait_ticks(3);
        in = 1'b0; step();
        tf = ticks;
        wait_ticks(8);
        chk("click_count", n_click, 1);
        chk("click_delay", t_click - tf, 5);
        chk("click_others", n_dclick + n_long + n_rpt, 0);

        // Double click: dclick captured by the first edge after the second release.
        sync_tick(); clr_log();
        in = 1'b1; wait_ticks(2);
        in = 1'b0; wait_ticks(2);
        in = 1'b1; wait_ticks(2);
        in = 1'b0; c0 = cyc;
        step();
        chk("dclick_cycle", c_dclick - c0, 1);
        wait_ticks(8);
        chk("dclick_count", n_dclick, 1);
        chk("dclick_noclick", n_click + n_long + n_rpt, 0);

        // Hold 20 ticks: long at 8, repeats at 12/16/20, held tracks the hold.
        sync_tick(); clr_log();
        in = 1'b1; t0 = ticks; held_bad = 0;
        while (ticks < t0 + 20) begin
            step();
            if (held !== ((ticks - t0) >= 8)) held_bad++;
        end
        chk("hold_long_count", n_long, 1);
        chk("hold_long_tick", t_long - t0, 8);
        chk("hold_rpt_count", rpt_t.size(), 3);
        for (int k = 0; k < 3 && k < rpt_t.size(); k++)
            chk($sformatf("hold_rpt%0d_tick", k), rpt_t[k] - t0, 12 + 4 * k);
        chk("hold_held_level", held_bad, 0);
        in = 1'b0; step(); step();
        chk("hold_release_held", int'(held), 0);
        wait_ticks(8);
        chk("hold_release_noclick", n_click + n_dclick, 0);

        // Release on the 8th tick: edge wins, no long_press, click 5 ticks later.
        sync_tick(); clr_log();
        in = 1'b1; t0 = ticks;
        wait_ticks(7);
        step(); step(); step();
        in = 1'b0; step();
        chk("edge8_fall_tick", ticks - t0, 8);
        tf = ticks;
        wait_ticks(7);
        chk("edge8_nolong", n_long + int'(held), 0);
        chk("edge8_click_count", n_click, 1);
        chk("edge8_click_delay", t_click - tf, 5);

        // Reset in LONGHOLD with key still down: silent until released and pressed again.
        sync_tick(); clr_log();
        in = 1'b1;
        wait_ticks(9);
        chk("rst_pre_held", int'(held), 1);
        clr_log();
        do_reset();
        step();
        chk("rst_outputs", int'({held, rpt, long_press, dclick, click}), 0);
        wait_ticks(20);
        chk("rst_no_events", n_click + n_dclick + n_long + n_rpt, 0);
        chk("rst_held_low", int'(held), 0);
        in = 1'b0; wait_ticks(2);
        in = 1'b1; t0 = ticks;
        wait_ticks(9);
        chk("rst_new_long_count", n_long, 1);
        chk("rst_new_long_tick", t_long - t0, 8);
        in = 1'b0; wait_ticks(2);

        chk("one_event_per_cycle", multi, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
